// File: rtl/bp_me_pkg.sv
// Shared BedRock memory-message types, payload masks and helpers for the
// memory command responder.
package bp_me_pkg;

    typedef enum logic [3:0] {
        e_bedrock_mem_rd    = 4'd0,
        e_bedrock_mem_wr    = 4'd1,
        e_bedrock_mem_uc_rd = 4'd2,
        e_bedrock_mem_uc_wr = 4'd3,
        e_bedrock_mem_pre   = 4'd4,
        e_bedrock_mem_amo   = 4'd5
    } bp_bedrock_mem_type_e;

    typedef enum logic [2:0] {
        e_bedrock_msg_size_1   = 3'd0,
        e_bedrock_msg_size_2   = 3'd1,
        e_bedrock_msg_size_4   = 3'd2,
        e_bedrock_msg_size_8   = 3'd3,
        e_bedrock_msg_size_16  = 3'd4,
        e_bedrock_msg_size_32  = 3'd5,
        e_bedrock_msg_size_64  = 3'd6,
        e_bedrock_msg_size_128 = 3'd7
    } bp_bedrock_msg_size_e;

    // One bit per msg_type: set where the command (wr, uc_wr) or response (rd, uc_rd) has data
    localparam logic [15:0] mem_cmd_payload_mask_gp  = 16'h000A;
    localparam logic [15:0] mem_resp_payload_mask_gp = 16'h0005;

    // Header layout, LSB first: msg_type, subop, addr, size, payload
    localparam int unsigned bedrock_type_width_gp    = 4;
    localparam int unsigned bedrock_subop_width_gp   = 4;
    localparam int unsigned bedrock_size_width_gp    = 3;
    localparam int unsigned bedrock_payload_width_gp = 16;
    localparam int unsigned bedrock_addr_lsb_gp      = bedrock_type_width_gp
                                                       + bedrock_subop_width_gp;

    typedef enum logic [1:0] {
        e_ready,
        e_wdata,
        e_ack,
        e_rdata
    } bp_me_mem_responder_state_e;

    function automatic int unsigned bp_me_header_width(input int unsigned paddr_width);
        return bedrock_addr_lsb_gp + paddr_width + bedrock_size_width_gp
               + bedrock_payload_width_gp;
    endfunction

    function automatic logic [7:0] bp_me_beats(input logic [2:0] size,
                                               input int unsigned lg_beat_bytes);
        if (32'(size) <= lg_beat_bytes) begin
            return 8'd1;
        end
        return 8'(32'd1 << (32'(size) - lg_beat_bytes));
    endfunction

endpackage

// File: rtl/bp_me_mem_responder_storage.sv
// Word array with one combinational read port and one byte-masked write port.
module bp_me_mem_responder_storage #(
    parameter int unsigned width_p   = 64,
    parameter int unsigned els_p     = 1024,
    parameter int unsigned lg_els_lp = $clog2(els_p)
) (
    input  logic                   clk_i,
    input  logic                   w_v_i,
    input  logic [lg_els_lp-1:0]   w_addr_i,
    input  logic [width_p-1:0]     w_data_i,
    input  logic [width_p/8-1:0]   w_mask_i,
    input  logic [lg_els_lp-1:0]   r_addr_i,
    output logic [width_p-1:0]     r_data_o
);

    logic [width_p-1:0] mem_q [els_p];

    always_ff @(posedge clk_i) begin
        if (w_v_i) begin
            for (int unsigned b = 0; b < width_p / 8; b++) begin
                if (w_mask_i[b]) begin
                    mem_q[w_addr_i][8*b +: 8] <= w_data_i[8*b +: 8];
                end
            end
        end
    end

    assign r_data_o = mem_q[r_addr_i];

endmodule

// File: rtl/bp_me_mem_cmd_responder.sv
// Memory-side BedRock endpoint: stores write beats, returns read data or an ack,
// one outstanding command at a time.
module bp_me_mem_cmd_responder
    import bp_me_pkg::*;
#(
    parameter int unsigned paddr_width_p       = 40,
    parameter int unsigned data_width_p        = 64,
    parameter int unsigned mem_els_p           = 1024,
    parameter int unsigned mem_header_width_lp = bp_me_header_width(paddr_width_p)
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic [mem_header_width_lp-1:0] mem_cmd_header_i,
    input  logic [data_width_p-1:0]        mem_cmd_data_i,
    input  logic                           mem_cmd_v_i,
    output logic                           mem_cmd_ready_and_o,
    input  logic                           mem_cmd_last_i,
    output logic [mem_header_width_lp-1:0] mem_resp_header_o,
    output logic [data_width_p-1:0]        mem_resp_data_o,
    output logic                           mem_resp_v_o,
    input  logic                           mem_resp_ready_and_i,
    output logic                           mem_resp_last_o
);

    localparam int unsigned beat_bytes_lp    = data_width_p / 8;
    localparam int unsigned lg_beat_bytes_lp = $clog2(beat_bytes_lp);
    localparam int unsigned lg_els_lp        = $clog2(mem_els_p);
    localparam int unsigned size_lsb_lp      = bedrock_addr_lsb_gp + paddr_width_p;
    localparam int unsigned idx_lsb_lp       = bedrock_addr_lsb_gp + lg_beat_bytes_lp;

    bp_me_mem_responder_state_e state_q, state_d;
    logic [mem_header_width_lp-1:0] hdr_q, hdr_d;
    logic [7:0] cnt_q, cnt_d;

    logic                        in_ready;
    logic [3:0]                  cur_type;
    logic [2:0]                  cur_size;
    logic [lg_els_lp-1:0]        cur_idx;
    logic [lg_beat_bytes_lp-1:0] cur_off;
    logic [7:0]                  cur_beats, beat;
    logic                        cur_is_wr, cur_is_rd;
    logic [lg_els_lp-1:0]        word_addr;
    logic [beat_bytes_lp-1:0]    w_mask;
    logic [data_width_p-1:0]     rdata;
    logic                        cmd_hs, resp_hs, w_v, cmd_last_exp;

    // In e_ready the incoming header is live; afterwards the latched copy governs
    assign in_ready  = (state_q == e_ready);
    assign cur_type  = in_ready ? mem_cmd_header_i[0 +: 4] : hdr_q[0 +: 4];
    assign cur_size  = in_ready ? mem_cmd_header_i[size_lsb_lp +: 3] : hdr_q[size_lsb_lp +: 3];
    assign cur_idx   = in_ready ? mem_cmd_header_i[idx_lsb_lp +: lg_els_lp]
                                : hdr_q[idx_lsb_lp +: lg_els_lp];
    assign cur_off   = in_ready ? mem_cmd_header_i[bedrock_addr_lsb_gp +: lg_beat_bytes_lp]
                                : hdr_q[bedrock_addr_lsb_gp +: lg_beat_bytes_lp];
    assign cur_beats = bp_me_beats(cur_size, lg_beat_bytes_lp);
    assign cur_is_wr = mem_cmd_payload_mask_gp[cur_type];
    assign cur_is_rd = mem_resp_payload_mask_gp[cur_type];
    assign beat      = in_ready ? 8'd0 : cnt_q;
    assign word_addr = cur_idx + lg_els_lp'(beat);

    assign mem_cmd_ready_and_o = reset_n_i && (state_q == e_ready || state_q == e_wdata);
    assign cmd_hs  = mem_cmd_v_i & mem_cmd_ready_and_o;
    assign resp_hs = mem_resp_v_o & mem_resp_ready_and_i;
    assign w_v     = cmd_hs & cur_is_wr;
    assign mem_resp_header_o = hdr_q;

    // Sub-word writes touch only [offset, offset + 2^size); data arrives replicated
    always_comb begin
        w_mask = '0;
        if (32'(cur_size) >= lg_beat_bytes_lp) begin
            w_mask = '1;
        end else begin
            for (int unsigned b = 0; b < beat_bytes_lp; b++) begin
                w_mask[b] = (b >= 32'(cur_off)) && (b < 32'(cur_off) + (32'd1 << cur_size));
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        hdr_d           = hdr_q;
        cnt_d           = cnt_q;
        mem_resp_v_o    = 1'b0;
        mem_resp_last_o = 1'b0;
        mem_resp_data_o = '0;
        unique case (state_q)
            e_ready: begin
                if (cmd_hs) begin
                    hdr_d = mem_cmd_header_i;
                    cnt_d = 8'd0;
                    if (cur_is_wr) begin
                        // Beat 0 commits here, so the counter already points at beat 1
                        if (cur_beats > 8'd1) begin
                            state_d = e_wdata;
                            cnt_d   = 8'd1;
                        end else begin
                            state_d = e_ack;
                        end
                    end else if (cur_is_rd) begin
                        state_d = e_rdata;
                    end else begin
                        state_d = e_ack;
                    end
                end
            end
            e_wdata: begin
                if (cmd_hs) begin
                    if (cnt_q == cur_beats - 8'd1) begin
                        state_d = e_ack;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            e_ack: begin
                mem_resp_v_o    = 1'b1;
                mem_resp_last_o = 1'b1;
                if (resp_hs) begin
                    state_d = e_ready;
                end
            end
            e_rdata: begin
                mem_resp_v_o    = 1'b1;
                mem_resp_data_o = rdata;
                mem_resp_last_o = (cnt_q == cur_beats - 8'd1);
                if (resp_hs) begin
                    if (mem_resp_last_o) begin
                        state_d = e_ready;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = e_ready;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= e_ready;
            hdr_q   <= '0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            hdr_q   <= hdr_d;
            cnt_q   <= cnt_d;
        end
    end

    bp_me_mem_responder_storage #(
        .width_p (data_width_p),
        .els_p   (mem_els_p)
    ) storage (
        .clk_i    (clk_i),
        .w_v_i    (w_v),
        .w_addr_i (word_addr),
        .w_data_i (mem_cmd_data_i),
        .w_mask_i (w_mask),
        .r_addr_i (word_addr),
        .r_data_o (rdata)
    );

    // Sender's last flag must match the beat count derived from size
    assign cmd_last_exp = in_ready ? !(cur_is_wr && cur_beats > 8'd1)
                                   : (cnt_q == cur_beats - 8'd1);

    cmd_last_matches_size: assert property (
        @(posedge clk_i) disable iff (!reset_n_i) cmd_hs |-> (mem_cmd_last_i == cmd_last_exp));

endmodule

// File: tb/tb_bp_me_mem_cmd_responder.sv
// Randomized scoreboard bench for bp_me_mem_cmd_responder against a byte-level memory model.
module tb_bp_me_mem_cmd_responder;
    import bp_me_pkg::*;

    localparam int HW = 67;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [HW-1:0] cmd_hdr = '0;
    logic [63:0]   cmd_data = '0;
    logic          cmd_v = 1'b0;
    logic          cmd_ready;
    logic          cmd_last = 1'b0;
    logic [HW-1:0] resp_hdr;
    logic [63:0]   resp_data;
    logic          resp_v;
    logic          resp_ready = 1'b0;
    logic          resp_last;

    bp_me_mem_cmd_responder dut (
        .clk_i                (clk),
        .reset_n_i            (rst_n),
        .mem_cmd_header_i     (cmd_hdr),
        .mem_cmd_data_i       (cmd_data),
        .mem_cmd_v_i          (cmd_v),
        .mem_cmd_ready_and_o  (cmd_ready),
        .mem_cmd_last_i       (cmd_last),
        .mem_resp_header_o    (resp_hdr),
        .mem_resp_data_o      (resp_data),
        .mem_resp_v_o         (resp_v),
        .mem_resp_ready_and_i (resp_ready),
        .mem_resp_last_o      (resp_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [HW-1:0] hdr;
        logic [63:0]   data;
        logic          last;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] model [1024];
    logic [63:0] wbeats [16];
    int          errors = 0;
    int          checks = 0;
    int          pops = 0;
    bit          always_ready = 1'b1;
    int          stall_beat = -1;
    int          stall_left = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Response monitor: choose ready, then compare whatever is handed over this cycle
    initial begin : monitor
        int   beat_idx = 0;
        bit   have_hold = 0;
        exp_t held;
        exp_t e;
        bit   r;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                have_hold = 0;
                beat_idx  = 0;
                continue;
            end
            if (have_hold) begin
                chk("stall_hold_v", resp_v, 1'b1);
                chk("stall_hold_data", resp_data, held.data);
                chk("stall_hold_last", resp_last, held.last);
                chk("stall_hold_hdr", resp_hdr, held.hdr);
            end
            if (resp_v && stall_left > 0 && beat_idx == stall_beat) begin
                r = 1'b0;
                stall_left--;
            end else begin
                r = always_ready ? 1'b1 : ($urandom_range(3) != 0);
            end
            resp_ready = r;
            have_hold  = 0;
            if (resp_v && r) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_resp", resp_v, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_data", resp_data, e.data);
                    chk("resp_last", resp_last, e.last);
                    chk("resp_hdr", resp_hdr, e.hdr);
                end
                beat_idx = resp_last ? 0 : beat_idx + 1;
                pops++;
            end else if (resp_v) begin
                have_hold = 1;
                held.hdr  = resp_hdr;
                held.data = resp_data;
                held.last = resp_last;
            end
        end
    end

    // Entered and left at a negedge
    task automatic cmd_beat(input logic [HW-1:0] hdr, input logic [63:0] data, input logic last);
        int n = 0;
        cmd_v = 1'b1;
        cmd_hdr = hdr;
        cmd_data = data;
        cmd_last = last;
        while (!cmd_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) chk("cmd_ready_timeout", cmd_ready, 1'b1);
        @(negedge clk);
        cmd_v = 1'b0;
        cmd_last = 1'b0;
    endtask

    task automatic send_msg(input logic [3:0] mt, input logic [2:0] sz, input logic [39:0] addr);
        logic [HW-1:0] hdr;
        int   nb, ncmd, idx, off, nbytes, w;
        bit   is_wr, is_rd;
        exp_t e;
        hdr    = {16'($urandom), sz, addr, 4'($urandom), mt};
        nbytes = 1 << sz;
        nb     = (nbytes > 8) ? nbytes / 8 : 1;
        is_wr  = (mt == e_bedrock_mem_wr) || (mt == e_bedrock_mem_uc_wr);
        is_rd  = (mt == e_bedrock_mem_rd) || (mt == e_bedrock_mem_uc_rd);
        idx    = int'(addr[12:3]);
        off    = int'(addr[2:0]);
        if (is_wr) begin
            for (int k = 0; k < nb; k++) begin
                w = (idx + k) % 1024;
                if (nbytes >= 8) model[w] = wbeats[k];
                else for (int b = off; b < off + nbytes; b++) model[w][8*b +: 8] = wbeats[k][8*b +: 8];
            end
        end
        if (is_rd) begin
            for (int k = 0; k < nb; k++) begin
                e.hdr = hdr; e.data = model[(idx + k) % 1024]; e.last = (k == nb - 1);
                exp_q.push_back(e);
            end
        end else begin
            e.hdr = hdr; e.data = '0; e.last = 1'b1;
            exp_q.push_back(e);
        end
        ncmd = is_wr ? nb : 1;
        for (int k = 0; k < ncmd; k++) begin
            cmd_beat(hdr, is_wr ? wbeats[k] : 64'($urandom), k == ncmd - 1);
        end
        chk("resp_latency", resp_v, 1'b1);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 32'(exp_q.size()), 0);
    endtask

    function automatic logic [63:0] replicate(input logic [63:0] d, input logic [2:0] sz);
        case (sz)
            3'd0: return {8{d[7:0]}};
            3'd1: return {4{d[15:0]}};
            3'd2: return {2{d[31:0]}};
            default: return d;
        endcase
    endfunction

    initial begin : stimulus
        logic [3:0] mt;
        logic [2:0] sz;
        logic [9:0] idx;
        logic [2:0] off;
        int         base;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_ready", cmd_ready, 1'b0);
            chk("reset_resp_v", resp_v, 1'b0);
            chk("reset_zero_outs", {resp_hdr, resp_data, resp_last}, '0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", cmd_ready, 1'b1);
        chk("resp_v_after_reset", resp_v, 1'b0);

        // Define every word before anything is read back
        for (int blk = 0; blk < 128; blk++) begin
            for (int k = 0; k < 8; k++) wbeats[k] = {$urandom, $urandom};
            send_msg(e_bedrock_mem_wr, e_bedrock_msg_size_64, 40'(blk * 64));
        end
        drain();

        wbeats[0] = 64'hDEADBEEF_CAFEF00D;
        send_msg(e_bedrock_mem_wr, e_bedrock_msg_size_8, 40'h40);
        send_msg(e_bedrock_mem_rd, e_bedrock_msg_size_8, 40'h40);

        for (int k = 0; k < 8; k++) wbeats[k] = 64'(k);
        send_msg(e_bedrock_mem_wr, e_bedrock_msg_size_64, 40'h1000);
        drain();
        stall_beat = 2;
        stall_left = 3;
        send_msg(e_bedrock_mem_rd, e_bedrock_msg_size_64, 40'h1000);
        drain();
        chk("stall_consumed", 32'(stall_left), 0);
        stall_beat = -1;

        wbeats[0] = 64'h1111111111111111;
        send_msg(e_bedrock_mem_wr, e_bedrock_msg_size_8, 40'h40);
        wbeats[0] = 64'hABABABABABABABAB;
        send_msg(e_bedrock_mem_uc_wr, e_bedrock_msg_size_1, 40'h43);
        send_msg(e_bedrock_mem_rd, e_bedrock_msg_size_8, 40'h40);

        for (int k = 0; k < 8; k++) wbeats[k] = 64'(k);
        send_msg(e_bedrock_mem_wr, e_bedrock_msg_size_64, 40'h1FE0);
        send_msg(e_bedrock_mem_rd, e_bedrock_msg_size_8, 40'h0);
        send_msg(e_bedrock_mem_rd, e_bedrock_msg_size_32, 40'h1FE0);
        drain();

        // Reset while beat 3 of an 8-beat read is on the bus
        base = pops;
        send_msg(e_bedrock_mem_rd, e_bedrock_msg_size_64, 40'h1000);
        for (int n = 0; n < 200 && pops < base + 3; n++) begin
            @(negedge clk);
            #1;
        end
        chk("pre_reset_pops", 32'(pops - base), 3);
        @(posedge clk);
        #2;
        chk("beat3_valid", resp_v, 1'b1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("reset_drops_resp_v", resp_v, 1'b0);
        chk("reset_drops_ready", cmd_ready, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_midreset", cmd_ready, 1'b1);
        send_msg(e_bedrock_mem_rd, e_bedrock_msg_size_8, 40'h40);
        send_msg(e_bedrock_mem_rd, e_bedrock_msg_size_8, 40'h1018);
        drain();

        always_ready = 1'b0;
        for (int t = 0; t < 100; t++) begin
            case ($urandom_range(4))
                0: mt = e_bedrock_mem_rd;
                1: mt = e_bedrock_mem_wr;
                2: mt = e_bedrock_mem_uc_rd;
                3: mt = e_bedrock_mem_uc_wr;
                default: mt = e_bedrock_mem_pre;
            endcase
            if (mt == e_bedrock_mem_pre) sz = e_bedrock_msg_size_8;
            else if (mt == e_bedrock_mem_uc_rd || mt == e_bedrock_mem_uc_wr) sz = 3'($urandom_range(3));
            else sz = 3'($urandom_range(6));
            idx = ($urandom_range(3) == 0) ? 10'(1016 + $urandom_range(7)) : 10'($urandom);
            off = (sz < 3) ? 3'(($urandom_range(7) >> sz) << sz) : 3'd0;
            for (int k = 0; k < 16; k++) wbeats[k] = replicate({$urandom, $urandom}, sz);
            send_msg(mt, sz, {27'($urandom), idx, off});
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/bp_me_mem_cmd_responder.md
# bp_me_mem_cmd_responder

Memory-side endpoint of the BedRock CCE↔memory command/response stream. It accepts mem_cmd beats, stores write data in a local byte-maskable word array, and returns one mem_resp message per command. Read types return data beats; every other type returns a header-only acknowledge. It is used as a behavioural DRAM stand-in behind a CCE in testbenches and small SoC configs, and handles one outstanding command at a time.

## Interface
- paddr_width_p, 40, physical address width
- data_width_p, 64, beat width in bits; power of two, 64..512
- mem_els_p, 1024, storage depth in data_width_p words; power of two
- mem_header_width_lp, derived, width of the BedRock mem header struct (msg_type, subop, addr, size, payload) from bp_common_pkg
- clk_i  in  1  clock
- reset_n_i  in  1  reset, asynchronous, active-low
- mem_cmd_header_i  in  mem_header_width_lp  command header, held stable across all beats of a message
- mem_cmd_data_i  in  data_width_p  command data beat
- mem_cmd_v_i  in  1  command beat valid
- mem_cmd_ready_and_o  out  1  command beat accepted when v & ready_and
- mem_cmd_last_i  in  1  final beat of the command message
- mem_resp_header_o  out  mem_header_width_lp  response header
- mem_resp_data_o  out  data_width_p  response data beat
- mem_resp_v_o  out  1  response beat valid
- mem_resp_ready_and_i  in  1  consumer accepts the beat
- mem_resp_last_o  out  1  final beat of the response message

## Operation
- Payload classification uses mem_cmd_payload_mask_gp and mem_resp_payload_mask_gp:
  - wr and uc_wr carry command data.
  - rd and uc_rd carry response data.
  - All other types are ack-only.
- Bytes per message: 2^size, where size is the bp_bedrock_msg_size_e encoding.
- Beats: max(1, 2^size / (data_width_p/8)).
- Word index: addr[log2(data_width_p/8) +: log2(mem_els_p)]. Beat k uses (index + k) mod mem_els_p, so the index wraps.
- Sub-word writes (2^size < data_width_p/8):
  - Data is replicated across the beat per BedRock convention.
  - Only bytes [addr_offset, addr_offset + 2^size) are written; all other bytes are preserved.
- Sub-word reads return the full aligned word unmodified.
- FSM states:
  - e_ready: ready_and = 1. On a beat handshake, latch the header and clear the beat counter.
    - Write type: commit beat 0. If beats > 1, go to e_wdata; otherwise go to e_ack.
    - Read type: go to e_rdata.
    - Other types: go to e_ack.
  - e_wdata: ready_and = 1. Each handshake commits the next word and increments the counter. The handshake with counter == beats-1 goes to e_ack.
  - e_ack: resp_v = 1, data = 0, last = 1. On handshake, go to e_ready.
  - e_rdata: resp_v = 1, data = mem[(index + cnt) mod mem_els_p], last = (cnt == beats-1). Each handshake increments cnt. The last handshake goes to e_ready.
- mem_cmd_ready_and_o = 0 in e_ack and e_rdata; there are no simultaneous command and response transfers.
- Response header is the latched command header, unchanged (msg_type, addr, size, payload).
- If mem_cmd_last_i disagrees with the computed beat count, it is a protocol error. Flag it with a simulation assertion; the computed count governs.
- Reset:
  - State → e_ready, counter → 0.
  - mem_resp_v_o = 0, mem_resp_last_o = 0, mem_resp_header_o = 0, mem_resp_data_o = 0.
  - mem_cmd_ready_and_o = 0 while reset is asserted, 1 from the first cycle after release.
  - Storage is not reset.
- Reset mid-message: the FSM aborts immediately. Beats already committed stay in storage, and the partial response is dropped.

## Timing
- Writes commit at the clock edge of the beat handshake.
- Reads are combinational from the word array, so a write at cycle t is visible to a read beat at t+1.
- Ack latency: resp_v is asserted the cycle after the last command beat is accepted.
- Read latency: first data beat is valid the cycle after command acceptance. A 64B read at 64-bit width with ready held high drives beats on cycles 1..8, last on cycle 8.
- Backpressure: while resp_v & ~ready_and, header, data and last hold stable.
- Throughput: one beat per cycle in each phase. The next command is accepted the cycle after the final response handshake.

## Structure
- bp_me_pkg:
  - Reuse the existing payload-mask constants.
  - Add the state enum bp_me_mem_responder_state_e.
  - Add the beat-count function as a shared helper.
- Sub-module bp_me_mem_responder_storage: a word array with one combinational read port, one write port, and a per-byte write mask. Mask generation and the rest of the logic stay in the top.

## Test plan
- Reset: hold reset_n_i low for 3 cycles, then release → mem_cmd_ready_and_o = 0 during reset and 1 the cycle after; resp_v = 0 throughout.
- 8B wr to 0x40 with data 0xDEADBEEF_CAFEF00D → ack with last = 1 and header equal to the command header, one cycle later. Then an 8B rd of 0x40 → single beat 0xDEADBEEF_CAFEF00D, last = 1.
- 64B wr to 0x1000 with beat k data = k (8 beats), then 64B rd of 0x1000:
  - Expect data 0..7 in order, last only on beat 7.
  - Drop ready_and for 3 cycles at beat 2 → data stays 2 and last stays 0 while stalled.
- 1B uc_wr to 0x43 with data 0xABABABABABABABAB over a word preloaded with 0x1111111111111111 → rd of 0x40 returns 0x11111111AB111111.
- Wrap (mem_els_p = 1024): 64B wr at word index 1020 with beats 0..7 → words 1020..1023 = 0..3 and words 0..3 = 4..7. A rd at index 0 returns 4.
- Assert reset_n_i during read beat 3 of 8 → resp_v drops asynchronously. After release, an 8B rd is served normally and storage contents are intact.
